mac_dot_sched: RTL and testbench

Sequencer that drives a single fixed-point multiply-accumulate datapath to compute the signed dot product of two length-`len` vectors.
- Operands are held in two external synchronous-read memories with 1-cycle read latency.
- The block issues addresses, accumulates a*b in a wide accumulator, rescales by Q and returns one N-bit result on a valid/ready output handshake.
- It sits between the layer control FSM (start/len) and the operand buffers, replacing per-element host sequencing of the MAC.

---
 rtl/mac_pkg.sv | 19 +
 rtl/mac_dot_acc.sv | 67 ++++++
 rtl/mac_dot_sched.sv | 97 +++++++++
 tb/tb_mac_dot_sched.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// rtl/mac_pkg.sv - shared state encoding, accumulator sizing and saturation limits for the dot-product MAC
package mac_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // Wide enough that 2**addr_w full-scale products can never overflow.
  function automatic int acc_width(input int n, input int addr_w);
    return 2 * n + addr_w + 1;
  endfunction

  function automatic longint sat_hi(input int n);
    return (longint'(1) <<< (n - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int n);
    return -(longint'(1) <<< (n - 1));
  endfunction

endpackage

// File: rtl/mac_dot_acc.sv
// rtl/mac_dot_acc.sv - signed multiply, wide accumulate, Q rescale; MAC_DOT_SAT_EN selects clamping over wrap
module mac_dot_acc
  import mac_pkg::*;
#(
  parameter int N      = 16,
  parameter int Q      = 12,
  parameter int ADDR_W = 8
) (
  input  logic         clk,
  input  logic         sclr,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [N-1:0] a_data,
  input  logic [N-1:0] b_data,
  output logic [N-1:0] result
);

  localparam int ACC_W = acc_width(N, ADDR_W);

  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_next;
  logic [N-1:0]            result_next;

  assign prod = $signed(a_data) * $signed(b_data);

  always_comb begin
    acc_next = acc;
    if (clr)
      acc_next = '0;
    else if (en)
      acc_next = acc + ACC_W'(prod);
  end

  // Result is taken from acc_next so the final product lands in the same cycle DONE is entered.
`ifdef MAC_DOT_SAT_EN
  localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(N));
  localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(N));

  logic signed [ACC_W-1:0] scaled;

  assign scaled = acc_next >>> Q;

  always_comb begin
    result_next = scaled[N-1:0];
    if (scaled > HI)
      result_next = HI[N-1:0];
    else if (scaled < LO)
      result_next = LO[N-1:0];
  end
`else
  assign result_next = acc_next[Q+N-1:Q];
`endif

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      acc    <= '0;
      result <= '0;
    end else begin
      acc <= acc_next;
      if (load)
        result <= result_next;
    end
  end

endmodule

// File: rtl/mac_dot_sched.sv
// rtl/mac_dot_sched.sv - dot-product sequencer: FSM, operand address issue and result handshake
module mac_dot_sched
  import mac_pkg::*;
#(
  parameter int N      = 16,
  parameter int Q      = 12,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              sclr,
  input  logic              start,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [N-1:0]      a_data,
  input  logic [N-1:0]      b_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      result
);

  state_t          state;
  logic [ADDR_W:0] len_q;
  logic            rd_valid;
  logic            clr;
  logic            load;

  assign clr  = (state == IDLE) && start;
  assign load = (state == DRAIN) || (clr && (len == '0));

  always_ff @(posedge clk or posedge sclr) begin
    if (sclr) begin
      state     <= IDLE;
      len_q     <= '0;
      busy      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr   <= '0;
      rd_valid  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      case (state)
        IDLE: begin
          if (start) begin
            len_q <= len;
            busy  <= 1'b1;
            if (len == '0) begin
              state     <= DONE;
              out_valid <= 1'b1;
            end else begin
              state   <= ISSUE;
              rd_en   <= 1'b1;
              rd_addr <= '0;
            end
          end
        end
        ISSUE: begin
          if ({1'b0, rd_addr} == len_q - (ADDR_W + 1)'(1)) begin
            state <= DRAIN;
            rd_en <= 1'b0;
          end else begin
            rd_addr <= rd_addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state     <= DONE;
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  mac_dot_acc #(
    .N     (N),
    .Q     (Q),
    .ADDR_W(ADDR_W)
  ) u_acc (
    .clk   (clk),
    .sclr  (sclr),
    .clr   (clr),
    .en    (rd_valid),
    .load  (load),
    .a_data(a_data),
    .b_data(b_data),
    .result(result)
  );

endmodule

// File: tb/tb_mac_dot_sched.sv
// tb/tb_mac_dot_sched.sv - scoreboard bench for mac_dot_sched against an arithmetic dot-product model
module tb_mac_dot_sched;

  logic        clk = 1'b0;
  logic        sclr;
  logic        start;
  logic [8:0]  len;
  logic        busy;
  logic        rd_en;
  logic [7:0]  rd_addr;
  logic [15:0] a_data;
  logic [15:0] b_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;

  logic [15:0] mem_a [256];
  logic [15:0] mem_b [256];
  logic [15:0] exp_q [$];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mac_dot_sched dut (
    .clk      (clk),
    .sclr     (sclr),
    .start    (start),
    .len      (len),
    .busy     (busy),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .a_data   (a_data),
    .b_data   (b_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  // Operand memories: one-cycle read latency, junk on the bus when not read.
  always @(posedge clk) begin
    if (rd_en) begin
      a_data <= mem_a[rd_addr];
      b_data <= mem_b[rd_addr];
    end else begin
      a_data <= 16'($urandom);
      b_data <= 16'($urandom);
    end
  end

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] model(input int l);
    longint acc;
    longint s;
    acc = 0;
    for (int i = 0; i < l; i++)
      acc += longint'($signed(mem_a[i])) * longint'($signed(mem_b[i]));
    s = acc >>> 12;
`ifdef MAC_DOT_SAT_EN
    if (s > 32767)
      s = 32767;
    else if (s < -32768)
      s = -32768;
`endif
    return s[15:0];
  endfunction

  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (out_valid && out_ready && !sclr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result", result, e);
        end
      end
    end
  endtask

  task automatic fill(input int l, input logic [15:0] a, input logic [15:0] b, input bit rnd);
    for (int i = 0; i < l; i++) begin
      mem_a[i] = rnd ? 16'($urandom) : a;
      mem_b[i] = rnd ? 16'($urandom) : b;
    end
  endtask

  // mode 0: ready held high; 1: random ready; 2: ready low for 5 cycles with start pulses
  task automatic do_run(input int l, input int mode);
    int c;
    int seen_rd;
    int bad;
    int w;
    bit got;
    logic [15:0] held;
    @(posedge clk); #1;
    out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    start = 1'b1;
    len   = 9'(l);
    exp_q.push_back(model(l));
    @(posedge clk); #1;
    start = 1'b0;
    c = 1; seen_rd = 0; bad = 0; got = 0;
    while (!got && c < 600) begin
      @(negedge clk);
      if (rd_en) begin
        if (rd_addr != seen_rd[7:0]) bad++;
        seen_rd++;
      end
      if (out_valid) got = 1;
      else begin
        @(posedge clk); #1;
        c++;
      end
    end
    chk("rd_count", seen_rd, l);
    chk("addr_seq", bad, 0);
    chk("valid_cycle", c, (l == 0) ? 1 : l + 2);
    if (!got) return;
    if (mode == 2) begin
      held = result;
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        start = (k == 2);
        @(negedge clk);
        chk("hold_result", result, held);
        chk("hold_busy", {busy, out_valid}, 2'b11);
      end
      @(posedge clk); #1;
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
    end
    w = 0;
    while (!(out_valid && out_ready) && w < 100) begin
      @(posedge clk); #1;
      out_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      w++;
    end
    chk("handshake_seen", (out_valid && out_ready), 1);
    @(posedge clk); #1;
    start = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("valid_drop", out_valid, 0);
    chk("busy_after", busy, 0);
  endtask

  initial begin
    sclr = 1'b1; start = 1'b0; len = '0; out_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    fork
      monitor();
    join_none
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_result", result, 0);
    @(posedge clk); #1;
    sclr = 1'b0;

    fill(4, 16'h1000, 16'h1000, 0);
    chk("model_unity", model(4), 16'h4000);
    do_run(4, 0);
    do_run(0, 0);
    fill(2, 16'hF000, 16'h0800, 0);
    do_run(2, 0);
    fill(8, 16'h7FFF, 16'h7FFF, 0);
    do_run(8, 0);
    fill(3, 16'h0, 16'h0, 1);
    do_run(3, 2);
    fill(5, 16'h0, 16'h0, 1);
    do_run(5, 0);

    // Abort a len=8 run in its cycle 3, then verify a clean len=1 run.
    fill(8, 16'h7FFF, 16'h7FFF, 0);
    @(posedge clk); #1;
    start = 1'b1; len = 9'd8;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #2 sclr = 1'b1;
    #1;
    chk("abort_outputs", {busy, rd_en, out_valid, rd_addr, result}, 0);
    @(posedge clk); #1;
    sclr = 1'b0;
    fill(1, 16'h1000, 16'h1000, 0);
    do_run(1, 0);

    for (int r = 0; r < 10; r++) begin
      int l;
      l = (r == 0) ? 256 : (r == 1) ? 0 : $urandom_range(1, 20);
      fill(l, 16'h0, 16'h0, 1);
      do_run(l, 1);
    end

    repeat (3) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
